// File: rtl/pxi_lb_pkg.sv
// Shared definitions for the PXI local-bus target.
// Contents:
//   - local-bus width constants (data, byte enables, word address range)
//   - target FSM state encoding
//   - helper that converts the wait-state parameter into a counter load value
package pxi_lb_pkg;

   localparam int LB_DATA_W   = 32;
   localparam int LB_BE_W     = 4;
   localparam int LB_ADDR_MSB = 31;
   localparam int LB_ADDR_LSB = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RREQ  = 3'd1,
      RCAP  = 3'd2,
      RWAIT = 3'd3,
      WWAIT = 3'd4,
      BEAT  = 3'd5
   } lb_state_t;

   // Wait-state counts are 0..15; larger values are clipped so the
   // 4-bit counter never silently wraps.
   function automatic logic [3:0] wait_load(input int ws);
      if (ws > 15) begin
         return 4'd15;
      end
      return 4'(ws);
   endfunction

endpackage

// File: rtl/pxi_lb_target.sv
// PXI local-bus target stage.
// Decodes a BASE_ADDR window on the latched word address and runs single or
// burst read/write data phases, turning every beat into a user register
// strobe. All outputs are registered.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   ADS_N, LQA, LW_R    address strobe, latched word address, direction
//   BLAST_N, LBE_N      last-beat flag, active-low byte enables
//   LD_IN               write data from the master
//   LD_OUT, LD_OE       read data to the master and its tristate enable
//   READY_N             beat ready, active low
//   USR_WR, USR_RD      one-cycle write strobe / read request
//   USR_ADDR            word offset inside the window
//   USR_WDATA, USR_BE   write data and active-high byte enables
//   USR_RDATA           read data, valid one cycle after USR_RD
module pxi_lb_target
   import pxi_lb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
   parameter int          ADDR_BITS   = 8,
   parameter int          WAIT_STATES = 1
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic                           ADS_N,
   input  logic [LB_ADDR_MSB:LB_ADDR_LSB] LQA,
   input  logic                           LW_R,
   input  logic                           BLAST_N,
   input  logic [LB_BE_W-1:0]             LBE_N,
   input  logic [LB_DATA_W-1:0]           LD_IN,
   output logic [LB_DATA_W-1:0]           LD_OUT,
   output logic                           LD_OE,
   output logic                           READY_N,
   output logic                           USR_WR,
   output logic                           USR_RD,
   output logic [ADDR_BITS-1:0]           USR_ADDR,
   output logic [LB_DATA_W-1:0]           USR_WDATA,
   output logic [LB_BE_W-1:0]             USR_BE,
   input  logic [LB_DATA_W-1:0]           USR_RDATA
);

   localparam logic       SKIP_WAIT = (WAIT_STATES == 0);
   localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_STATES);

   lb_state_t            state_reg;
   logic [3:0]           cnt_reg;
   logic [ADDR_BITS-1:0] off_reg;
   logic                 wr_reg;

   logic                 hit;
   logic [ADDR_BITS-1:0] lqa_off;
   logic [ADDR_BITS-1:0] off_inc;

   assign hit     = (LQA[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
   assign lqa_off = LQA[ADDR_BITS+1:2];
   assign off_inc = off_reg + ADDR_BITS'(1);   // wraps modulo the window size

   // READY_N is registered, so it is pulled low on the same edge that enters
   // BEAT; it is therefore low exactly while the FSM sits in BEAT.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         off_reg   <= '0;
         wr_reg    <= 1'b0;
         READY_N   <= 1'b1;
         LD_OE     <= 1'b0;
         LD_OUT    <= '0;
         USR_WR    <= 1'b0;
         USR_RD    <= 1'b0;
         USR_ADDR  <= '0;
         USR_WDATA <= '0;
         USR_BE    <= '0;
      end else begin
         READY_N <= 1'b1;
         USR_WR  <= 1'b0;
         USR_RD  <= 1'b0;

         case (state_reg)
            IDLE: begin
               if (!ADS_N && hit) begin
                  off_reg <= lqa_off;
                  cnt_reg <= WAIT_LOAD;
                  wr_reg  <= LW_R;
                  if (LW_R) begin
                     if (SKIP_WAIT) begin
                        state_reg <= BEAT;
                        READY_N   <= 1'b0;
                     end else begin
                        state_reg <= WWAIT;
                     end
                  end else begin
                     state_reg <= RREQ;
                     USR_RD    <= 1'b1;
                     USR_ADDR  <= lqa_off;
                     LD_OE     <= 1'b1;
                  end
               end
            end

            // USR_RD is high during this state; the user data arrives next cycle.
            RREQ: begin
               state_reg <= RCAP;
            end

            RCAP: begin
               LD_OUT <= USR_RDATA;
               if (SKIP_WAIT) begin
                  state_reg <= BEAT;
                  READY_N   <= 1'b0;
               end else begin
                  state_reg <= RWAIT;
               end
            end

            // cnt_reg holds the wait cycles still to spend, including the
            // current one, so the wait state lasts exactly WAIT_STATES cycles.
            RWAIT, WWAIT: begin
               if (cnt_reg <= 4'd1) begin
                  cnt_reg   <= '0;
                  state_reg <= BEAT;
                  READY_N   <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end

            BEAT: begin
               if (wr_reg) begin
                  USR_WR    <= 1'b1;
                  USR_WDATA <= LD_IN;
                  USR_BE    <= ~LBE_N;
                  USR_ADDR  <= off_reg;
               end
               if (!BLAST_N) begin
                  state_reg <= IDLE;
                  LD_OE     <= 1'b0;
               end else begin
                  off_reg <= off_inc;
                  cnt_reg <= WAIT_LOAD;
                  if (wr_reg) begin
                     if (SKIP_WAIT) begin
                        state_reg <= BEAT;
                        READY_N   <= 1'b0;
                     end else begin
                        state_reg <= WWAIT;
                     end
                  end else begin
                     state_reg <= RREQ;
                     USR_RD    <= 1'b1;
                     USR_ADDR  <= off_inc;
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
               LD_OE     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pxi_lb_target.sv
// Self-checking bench for pxi_lb_target.
// Two instances share the bus inputs: "dut" uses the default window at
// 0x4000 with one wait state, "dut0" sits at 0x0000 with no wait states, so
// each transfer hits exactly one of them. A random master reacts to READY_N,
// and expectations come from the bus timing rules (latency and beat period
// per direction) and a simple user-register memory.
module tb_pxi_lb_target;

   logic        clk = 1'b0;
   logic        rst;
   logic        ads_n;
   logic [29:0] lqa;
   logic        lw_r;
   logic        blast_n;
   logic [3:0]  lbe_n;
   logic [31:0] ld_in;

   logic [31:0] ld_out1, usr_wdata1, usr_rdata1;
   logic        ld_oe1, ready_n1, usr_wr1, usr_rd1;
   logic [7:0]  usr_addr1;
   logic [3:0]  usr_be1;

   logic [31:0] ld_out0, usr_wdata0, usr_rdata0;
   logic        ld_oe0, ready_n0, usr_wr0, usr_rd0;
   logic [7:0]  usr_addr0;
   logic [3:0]  usr_be0;

   logic [31:0] mem [256];
   int          checks   = 0;
   int          failures = 0;
   bit          use0     = 1'b0;

   logic [31:0] m_ld_out, m_usr_wdata;
   logic        m_ld_oe, m_ready_n, m_usr_wr, m_usr_rd;
   logic [7:0]  m_usr_addr;
   logic [3:0]  m_usr_be;

   always #5 clk = ~clk;

   pxi_lb_target dut (
      .CLK(clk), .RST(rst), .ADS_N(ads_n), .LQA(lqa), .LW_R(lw_r),
      .BLAST_N(blast_n), .LBE_N(lbe_n), .LD_IN(ld_in),
      .LD_OUT(ld_out1), .LD_OE(ld_oe1), .READY_N(ready_n1),
      .USR_WR(usr_wr1), .USR_RD(usr_rd1), .USR_ADDR(usr_addr1),
      .USR_WDATA(usr_wdata1), .USR_BE(usr_be1), .USR_RDATA(usr_rdata1)
   );

   pxi_lb_target #(.BASE_ADDR(32'h0000_0000), .ADDR_BITS(8), .WAIT_STATES(0)) dut0 (
      .CLK(clk), .RST(rst), .ADS_N(ads_n), .LQA(lqa), .LW_R(lw_r),
      .BLAST_N(blast_n), .LBE_N(lbe_n), .LD_IN(ld_in),
      .LD_OUT(ld_out0), .LD_OE(ld_oe0), .READY_N(ready_n0),
      .USR_WR(usr_wr0), .USR_RD(usr_rd0), .USR_ADDR(usr_addr0),
      .USR_WDATA(usr_wdata0), .USR_BE(usr_be0), .USR_RDATA(usr_rdata0)
   );

   // User register file: data is valid only in the cycle after USR_RD,
   // garbage otherwise.
   always @(posedge clk) begin
      usr_rdata1 <= usr_rd1 ? mem[usr_addr1] : $urandom();
      usr_rdata0 <= usr_rd0 ? mem[usr_addr0] : $urandom();
   end

   always_comb begin
      m_ld_out    = use0 ? ld_out0    : ld_out1;
      m_ld_oe     = use0 ? ld_oe0     : ld_oe1;
      m_ready_n   = use0 ? ready_n0   : ready_n1;
      m_usr_wr    = use0 ? usr_wr0    : usr_wr1;
      m_usr_rd    = use0 ? usr_rd0    : usr_rd1;
      m_usr_addr  = use0 ? usr_addr0  : usr_addr1;
      m_usr_wdata = use0 ? usr_wdata0 : usr_wdata1;
      m_usr_be    = use0 ? usr_be0    : usr_be1;
   end

   task automatic drive_junk();
      ads_n   = 1'b1;
      lqa     = 30'($urandom());
      lw_r    = 1'($urandom());
      blast_n = 1'($urandom());
      lbe_n   = 4'($urandom());
      ld_in   = $urandom();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_junk();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (ready_n1 !== 1'b1 || ld_oe1 !== 1'b0 || usr_wr1 !== 1'b0 || usr_rd1 !== 1'b0 ||
          ld_out1 !== 32'h0 || usr_addr1 !== 8'h0 || usr_wdata1 !== 32'h0 || usr_be1 !== 4'h0) begin
         failures++;
         $display("FAIL reset_state: ready_n=%b ld_oe=%b wr=%b rd=%b ld_out=%h addr=%h wdata=%h be=%h, required 1 0 0 0 0 0 0 0",
                  ready_n1, ld_oe1, usr_wr1, usr_rd1, ld_out1, usr_addr1, usr_wdata1, usr_be1);
      end
      checks++;
      if (ready_n0 !== 1'b1 || ld_oe0 !== 1'b0 || usr_wr0 !== 1'b0 || usr_rd0 !== 1'b0) begin
         failures++;
         $display("FAIL reset_state_ws0: ready_n=%b ld_oe=%b wr=%b rd=%b, required 1 0 0 0",
                  ready_n0, ld_oe0, usr_wr0, usr_rd0);
      end
      $display("txn reset: outputs checked after reset release");
   endtask

   // Runs one transfer against the selected instance and checks beat timing,
   // read data, user strobes and LD_OE against the bus timing rules.
   task automatic test_transfer(input string name, input bit sel0, input bit wr,
                                input logic [29:0] addr, input int nbeats,
                                input logic [31:0] d0, input logic [3:0] be0_n);
      int          ws = sel0 ? 0 : 1;
      logic [7:0]  off = addr[7:0];
      logic [31:0] wdata[$];
      logic [3:0]  wben[$];
      int          beat_cyc[$];
      logic [31:0] beat_ld[$];
      int          wr_cyc[$];
      logic [7:0]  wr_addr[$];
      logic [31:0] wr_data[$];
      logic [3:0]  wr_be[$];
      int          rd_cyc[$];
      logic [7:0]  rd_addr[$];
      int          first, period, last_exp, oe_bad, idx;
      logic [7:0]  a;

      use0 = sel0;
      for (int j = 0; j < nbeats; j++) begin
         wdata.push_back(j == 0 ? d0 : $urandom());
         wben.push_back(j == 0 ? be0_n : 4'($urandom()));
      end
      first    = wr ? 1 + ws : 3 + ws;
      period   = first;
      last_exp = first + (nbeats - 1) * period;
      oe_bad   = 0;

      @(negedge clk);
      ads_n = 1'b0;
      lqa   = addr;
      lw_r  = wr;
      for (int k = 1; k <= last_exp + 4; k++) begin
         @(negedge clk);
         drive_junk();
         if (m_usr_wr) begin
            wr_cyc.push_back(k); wr_addr.push_back(m_usr_addr);
            wr_data.push_back(m_usr_wdata); wr_be.push_back(m_usr_be);
         end
         if (m_usr_rd) begin
            rd_cyc.push_back(k); rd_addr.push_back(m_usr_addr);
         end
         if (!wr && k <= last_exp && m_ld_oe !== 1'b1) oe_bad++;
         if ((wr || k > last_exp) && m_ld_oe !== 1'b0) oe_bad++;
         if (m_ready_n === 1'b0) begin
            beat_cyc.push_back(k);
            beat_ld.push_back(m_ld_out);
            idx = beat_cyc.size() - 1;
            if (idx < nbeats) begin
               ld_in   = wdata[idx];
               lbe_n   = wben[idx];
               blast_n = (idx == nbeats - 1) ? 1'b0 : 1'b1;
            end else begin
               blast_n = 1'b0;
            end
         end else if (k < last_exp && $urandom_range(0, 3) == 0) begin
            // Stray address strobe inside the transfer must be ignored.
            ads_n = 1'b0;
            lqa   = {addr[29:8], 8'($urandom())};
         end
      end
      drive_junk();

      checks++;
      if (beat_cyc.size() != nbeats) begin
         failures++;
         $display("FAIL %s beat_count: got %0d, required %0d", name, beat_cyc.size(), nbeats);
      end
      for (int j = 0; j < nbeats; j++) begin
         a = off + 8'(j);
         checks++;
         if (j >= beat_cyc.size() || beat_cyc[j] != first + j * period) begin
            failures++;
            $display("FAIL %s beat%0d_cycle: got %0d, required %0d", name, j,
                     (j < beat_cyc.size()) ? beat_cyc[j] : -1, first + j * period);
         end
         if (!wr) begin
            checks++;
            if (j >= beat_ld.size() || beat_ld[j] !== mem[a]) begin
               failures++;
               $display("FAIL %s beat%0d_ld_out: got %h, required %h", name, j,
                        (j < beat_ld.size()) ? beat_ld[j] : 32'hx, mem[a]);
            end
            checks++;
            if (j >= rd_cyc.size() || rd_cyc[j] != first + j * period - (2 + ws) || rd_addr[j] !== a) begin
               failures++;
               $display("FAIL %s usr_rd%0d: got cycle %0d addr %h, required cycle %0d addr %h", name, j,
                        (j < rd_cyc.size()) ? rd_cyc[j] : -1, (j < rd_addr.size()) ? rd_addr[j] : 8'hx,
                        first + j * period - (2 + ws), a);
            end
         end else begin
            checks++;
            if (j >= wr_cyc.size() || wr_cyc[j] != first + j * period + 1 || wr_addr[j] !== a ||
                wr_data[j] !== wdata[j] || wr_be[j] !== ~wben[j]) begin
               failures++;
               $display("FAIL %s usr_wr%0d: got cycle %0d addr %h data %h be %h, required cycle %0d addr %h data %h be %h",
                        name, j, (j < wr_cyc.size()) ? wr_cyc[j] : -1,
                        (j < wr_addr.size()) ? wr_addr[j] : 8'hx, (j < wr_data.size()) ? wr_data[j] : 32'hx,
                        (j < wr_be.size()) ? wr_be[j] : 4'hx,
                        first + j * period + 1, a, wdata[j], ~wben[j]);
            end
         end
      end
      checks++;
      if (wr_cyc.size() != (wr ? nbeats : 0) || rd_cyc.size() != (wr ? 0 : nbeats)) begin
         failures++;
         $display("FAIL %s strobe_count: got wr=%0d rd=%0d, required wr=%0d rd=%0d", name,
                  wr_cyc.size(), rd_cyc.size(), wr ? nbeats : 0, wr ? 0 : nbeats);
      end
      checks++;
      if (oe_bad != 0) begin
         failures++;
         $display("FAIL %s ld_oe: got %0d bad cycles, required 0", name, oe_bad);
      end
      $display("txn %s: %s dut%0d off=%h beats=%0d seen=%0d", name, wr ? "write" : "read",
               sel0 ? 0 : 1, off, nbeats, beat_cyc.size());
   endtask

   task automatic test_miss();
      int bad = 0;
      @(negedge clk);
      ads_n = 1'b0;
      lqa   = 30'(32'h8000 >> 2);
      lw_r  = 1'($urandom());
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         drive_junk();
         lqa = {1'b1, 29'($urandom())};
         if (ready_n1 !== 1'b1 || ld_oe1 !== 1'b0 || usr_wr1 !== 1'b0 || usr_rd1 !== 1'b0 ||
             ready_n0 !== 1'b1 || ld_oe0 !== 1'b0 || usr_wr0 !== 1'b0 || usr_rd0 !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL miss_quiet: got %0d active cycles, required 0", bad);
      end
      $display("txn miss: addr 0x8000, %0d active cycles", bad);
   endtask

   task automatic test_reset_mid_read();
      int beats = 0;
      use0 = 1'b0;
      @(negedge clk);
      ads_n = 1'b0;
      lqa   = 30'(32'h4030 >> 2);
      lw_r  = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         drive_junk();
      end
      rst = 1'b1;   // asserted while the read sits in its wait state
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (ready_n1 !== 1'b1 || ld_oe1 !== 1'b0 || usr_wr1 !== 1'b0 || usr_rd1 !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_read: got ready_n=%b ld_oe=%b wr=%b rd=%b, required 1 0 0 0",
                  ready_n1, ld_oe1, usr_wr1, usr_rd1);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         drive_junk();
         if (ready_n1 !== 1'b1 || ld_oe1 !== 1'b0) beats++;
      end
      checks++;
      if (beats != 0) begin
         failures++;
         $display("FAIL reset_no_beat: got %0d active cycles, required 0", beats);
      end
      $display("txn reset_mid_read: aborted read checked");
      test_transfer("read_after_reset", 1'b0, 1'b0, 30'(32'h4030 >> 2), 1, 32'h0, 4'h0);
   endtask

   task automatic test_random();
      logic [29:0] a;
      bit          wr;
      for (int t = 0; t < 8; t++) begin
         wr = 1'($urandom());
         a  = {22'h10, 8'($urandom())};
         test_transfer($sformatf("random%0d", t), 1'b0, wr, a, $urandom_range(1, 4),
                       $urandom(), 4'($urandom()));
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      mem[8] = 32'h1234_5678;
      test_reset();
      test_transfer("single_write", 1'b0, 1'b1, 30'(32'h4010 >> 2), 1, 32'hDEAD_BEEF, 4'b0000);
      test_transfer("single_read",  1'b0, 1'b0, 30'(32'h4020 >> 2), 1, 32'h0, 4'h0);
      test_transfer("burst_wrap",   1'b0, 1'b1, 30'((32'h4000 + 32'h0FE * 4) >> 2), 4, $urandom(), 4'($urandom()));
      test_transfer("ws0_write",    1'b1, 1'b1, 30'h0000_0010, 3, $urandom(), 4'($urandom()));
      test_miss();
      test_reset_mid_read();
      test_transfer("ws0_read_burst", 1'b1, 1'b0, 30'h0, 2, 32'h0, 4'h0);
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
